// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN queue and its producer/consumer processes.
// Holds the writer FSM state encoding and the default token/counter widths so
// the queue and the processes attached to it agree on token width.
package kpn_pkg;

  localparam int unsigned KpnDataWidth  = 16;
  localparam int unsigned KpnCountWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } kpn_state_e;

endpackage

// File: rtl/kpn_token_gen.sv
// Arithmetic token generator: holds the current token value and a step.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   load            - load value <= load_value, step <= load_step
//   advance         - value <= value + step (wrapping); ignored when load=1
//   load_value      - initial token value
//   load_step       - increment between tokens
//   value           - current token (registered)
module kpn_token_gen #(
  parameter int unsigned DATA_WIDTH = kpn_pkg::KpnDataWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic [DATA_WIDTH-1:0] load_step,
  output logic [DATA_WIDTH-1:0] value
);

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;

  always_comb begin
    value_d = value_q;
    step_d  = step_q;
    if (load) begin
      value_d = load_value;
      step_d  = load_step;
    end else if (advance) begin
      value_d = value_q + step_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      step_q  <= '0;
    end else begin
      value_q <= value_d;
      step_q  <= step_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/kpn_queue_writer.sv
// KPN queue producer: on start, writes an arithmetic sequence of tokens into
// the queue with blocking-write semantics (stalls on full or pause, never
// drops or repeats a token).
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   start                     - begin a burst (sampled only in IDLE)
//   start_value, step, count  - burst configuration, latched on accepted start
//   pause                     - hold off writes without changing state
//   full                      - queue full flag
//   wr, data_out              - queue write strobe and token
//   busy                      - high while the burst is running
//   done                      - one-cycle pulse after the last token is accepted
//   sent, checksum            - accepted-token count and wrapping token sum
module kpn_queue_writer
  import kpn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = KpnDataWidth,
  parameter int unsigned COUNT_WIDTH = KpnCountWidth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  start_value,
  input  logic [DATA_WIDTH-1:0]  step,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   pause,
  input  logic                   full,
  output logic                   wr,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent,
  output logic [DATA_WIDTH-1:0]  checksum
);

  kpn_state_e state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic [DATA_WIDTH-1:0]  checksum_q, checksum_d;
  logic                   tok_load, tok_advance;
  logic [COUNT_WIDTH-1:0] sent_inc;

  kpn_token_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_token_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (tok_load),
    .advance   (tok_advance),
    .load_value(start_value),
    .load_step (step),
    .value     (data_out)
  );

  // Only wr is combinational on full/pause; everything else is registered.
  assign wr       = (state_q == StRun) && !full && !pause;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sent     = sent_q;
  assign checksum = checksum_q;
  assign sent_inc = sent_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sent_d      = sent_q;
    checksum_d  = checksum_q;
    tok_load    = 1'b0;
    tok_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tok_load   = 1'b1;
          count_d    = count;
          sent_d     = '0;
          checksum_d = '0;
          state_d    = (count != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        // A stalled cycle holds every register so the same token is re-presented.
        if (wr) begin
          tok_advance = 1'b1;
          sent_d      = sent_inc;
          checksum_d  = checksum_q + data_out;
          if (sent_inc == count_q) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      sent_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      checksum_q <= checksum_d;
    end
  end

endmodule

// File: doc/kpn_queue_writer.md
Name: kpn_queue_writer

Overview:
- Producer (write-side) process for the KPN queue; the counterpart to the queue's rd/output_1 read port.
- On start, emits an arithmetic sequence of DATA_WIDTH-bit tokens into the queue with KPN blocking-write semantics: it stalls while the queue reports full and never drops a token.
- Sits between the control logic (start/config) and the queue's write port.

Parameters:
- DATA_WIDTH, 16, token width; matches the queue data width.
- COUNT_WIDTH, 8, width of the token-count configuration and counters.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
- start_value  input  DATA_WIDTH  first token value; latched on accepted start.
- step  input  DATA_WIDTH  increment between tokens; latched on accepted start.
- count  input  COUNT_WIDTH  number of tokens to write; latched on accepted start.
- pause  input  1  when 1, holds off writes without changing state.
- full  input  1  queue full flag from the queue.
- wr  output  1  write strobe to the queue.
- data_out  output  DATA_WIDTH  token presented to the queue.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last token is accepted.
- sent  output  COUNT_WIDTH  tokens accepted so far in the current or last burst.
- checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of the tokens accepted in the burst.

Behaviour:
- Reset (asynchronous, any time): state IDLE; wr=0, data_out=0, busy=0, done=0, sent=0, checksum=0.
  - Reset mid-burst aborts the burst. Tokens already accepted by the queue are not retracted.
- States are IDLE, RUN and DONE.
- IDLE:
  - On start=1, latch start_value into data_out, and latch step and count. Clear sent and checksum.
  - Go to RUN if count!=0, otherwise go to DONE. No write occurs for count=0.
- RUN:
  - wr = !full && !pause (combinational from the registered state); busy=1.
  - A write is accepted on a rising edge where wr=1. On acceptance:
    - data_out <= data_out+step, wrapping modulo 2^DATA_WIDTH.
    - sent <= sent+1.
    - checksum <= checksum+data_out, wrapping.
  - If sent+1==count on acceptance, go to DONE.
  - A full or pause cycle holds every register; the same token is re-presented, which gives a blocking write.
  - full may toggle every cycle; a token is never repeated or skipped.
- DONE:
  - done=1 and wr=0 for exactly one cycle, then go to IDLE.
  - sent and checksum hold until the next accepted start.
- start outside IDLE is ignored, including start in the DONE cycle.
- Latency: the first wr can assert one cycle after start. With full=0 and pause=0, throughput is 1 token/cycle and N tokens take N cycles in RUN.
- data_out is registered; only wr depends combinationally on full and pause.
- count = 2^COUNT_WIDTH-1 is the maximum burst; sent never wraps.

Decomposition:
- Shared package kpn_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the DATA_WIDTH and COUNT_WIDTH defaults, so the queue and writer agree on token width.
- One sub-module, kpn_token_gen:
  - owns the token value register and step adder, with load/advance controls;
  - is reused by later source processes.
- The FSM, counters and checksum stay in kpn_queue_writer.

Test Plan:
1. Basic burst: start_value=5, step=3, count=4, full=0, pause=0.
   - Required: wr high for 4 consecutive cycles with data_out 5,8,11,14.
   - Then done pulses once, with sent=4 and checksum=38.
2. Backpressure: same configuration, full=1 in cycles 2-4 of RUN.
   - Required: wr=0 while full is high and data_out held at 8.
   - The queue receives exactly 5,8,11,14; done arrives 3 cycles later than in scenario 1.
3. Wrap-around: start_value=16'hFFFE, step=1, count=4.
   - Required: tokens FFFE, FFFF, 0000, 0001 and checksum=16'hFFFE.
4. Zero count and ignored start:
   - count=0: no wr, with done one cycle after start.
   - A start pulse during RUN of a count=3 burst leaves the sequence and count unchanged.
5. Reset mid-operation: reset asserted between clock edges after 2 of 6 tokens are accepted.
   - Required: all outputs are 0 immediately, without waiting for a clock.
   - After reset releases, a new start with start_value=100, step=1, count=2 produces 100,101.
6. Pause and full interleaved: pause and full toggle pseudo-randomly over a count=50, step=7 burst.
   - Required: the scoreboard sees exactly 50 tokens in arithmetic order, with no duplicates.
   - The final checksum equals the modular sum computed by the bench.
